lane_rotator: RTL and testbench
===============================

LANE_ROTATOR -- requirements
Module: lane_rotator

Interface
REQ-001 SHALL have parameter WIDTH, default 8, bits per lane (>=1).
REQ-002 SHALL have parameter LANES, default 4, number of lanes (>=2).
REQ-003 SHALL have port clk  input  1  clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port load_i  input  1  load data_i into lanes (IDLE only).
REQ-006 SHALL have port data_i  input  LANES*WIDTH  load data; lane k = bits [k*WIDTH +: WIDTH].
REQ-007 SHALL have port start_i  input  1  start a run (IDLE only).
REQ-008 SHALL have port mode_i  input  2  operation: 00 hold, 01 rotate left, 10 rotate right, 11 pair swap.
REQ-009 SHALL have port steps_i  input  8  number of operations in the run.
REQ-010 SHALL have port data_o  output  LANES*WIDTH  current lane contents, same packing as data_i.
REQ-011 SHALL have port busy_o  output  1  high while state is RUN.
REQ-012 SHALL have port done_o  output  1  one-cycle pulse on run completion.
REQ-013 SHALL have port ops_o  output  8  operations applied in the last run.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE; data_o, busy_o, done_o registered.
REQ-015 In IDLE, load_i=1 SHALL copy data_i into lanes at the next edge; state stays IDLE.
REQ-016 In IDLE, start_i=1 with load_i=0 SHALL latch mode_i and steps_i; go RUN if steps_i!=0, else DONE with lanes unchanged.
REQ-017 load_i and start_i both high in IDLE: load SHALL win and start SHALL be ignored.
REQ-018 load_i and start_i SHALL be ignored in RUN and DONE; mode_i/steps_i changes mid-run SHALL have no effect.
REQ-019 In RUN, each edge SHALL apply the latched op once and decrement the step counter; after the op that brings the counter to 0, state SHALL go DONE.
REQ-020 Latency: start sampled at edge 0 -> ops at edges 1..N -> done_o high in the cycle after edge N -> IDLE at edge N+1.
REQ-021 Rotate left: lane i SHALL take lane (i+1) mod LANES. Rotate right: lane i SHALL take lane (i-1) mod LANES.
REQ-022 Pair swap: lane 2k SHALL exchange with lane 2k+1; when LANES is odd, the last lane SHALL hold.
REQ-023 Hold: lanes SHALL be unchanged, but steps SHALL still be counted and the timing of REQ-020 kept.
REQ-024 With LANES=2, modes 01, 10 and 11 SHALL all swap the two lanes.

Reset
REQ-025 rst_n low SHALL immediately clear all lanes to 0, the state to IDLE, busy_o, done_o and ops_o to 0, and the step counter to 0, including mid-RUN.

Configuration
REQ-026 Macro LANE_ROTATOR_OPS_CNT_EN defined: ops_o SHALL clear at each start and increment per applied op; at done_o it SHALL equal the latched steps_i.
REQ-027 Macro LANE_ROTATOR_OPS_CNT_EN undefined: ops_o SHALL remain, tied to constant 0, with no counter logic.

Structure
REQ-028 Package lane_rotator_pkg SHALL hold the mode enum (HOLD, ROT_L, ROT_R, PAIR_SWAP), the state enum, and STEP_W=8.
REQ-029 SHALL be a single module with no sub-module; the lane array SHALL use generate loops over LANES.

Verification (WIDTH=8, LANES=4, loaded data 0x44332211)
REQ-030 Rotate left, steps=1 -> data_o=0x11443322; done_o high exactly one cycle after the op edge.
REQ-031 Rotate right, steps=1 -> data_o=0x33221144; pair swap, steps=1 -> data_o=0x33441122.
REQ-032 Rotate left, steps=4 -> busy_o high 4 cycles, data_o=0x44332211, ops_o=4 (macro on) or 0 (macro off).
REQ-033 steps=0 -> no busy_o, done_o next cycle, data_o unchanged; load_i+start_i same cycle -> load only, no done_o.
REQ-034 rst_n low during the 2nd of 5 steps -> data_o=0, busy_o=0, done_o=0 immediately; after release, IDLE and load works.
REQ-035 load_i=1 during RUN with data_i=0xAAAAAAAA -> ignored; the run completes on its original data.

Source files
------------

// File: rtl/lane_rotator_pkg.sv
// Shared types for the lane rotator: operation modes, FSM states and step width.
package lane_rotator_pkg;

    localparam int STEP_W = 8;

    typedef enum logic [1:0] {
        HOLD      = 2'b00,
        ROT_L     = 2'b01,
        ROT_R     = 2'b10,
        PAIR_SWAP = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/lane_rotator.sv
// Lane rotator: loads LANES lanes of WIDTH bits and applies a latched permutation a set number of times.
// Optional macro LANE_ROTATOR_OPS_CNT_EN enables the ops_o counter of applied operations.
module lane_rotator
    import lane_rotator_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LANES = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load_i,
    input  logic [LANES*WIDTH-1:0]   data_i,
    input  logic                     start_i,
    input  logic [1:0]               mode_i,
    input  logic [STEP_W-1:0]        steps_i,
    output logic [LANES*WIDTH-1:0]   data_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [STEP_W-1:0]        ops_o
);

    state_t              state;
    mode_t               mode_q;
    logic [STEP_W-1:0]   step_cnt;
    logic [WIDTH-1:0]    lanes_q   [LANES];
    logic [WIDTH-1:0]    lane_next [LANES];
    logic                load_en;
    logic                apply_en;

`ifdef LANE_ROTATOR_OPS_CNT_EN
    logic [STEP_W-1:0]   ops_q;
    assign ops_o = ops_q;
`else
    assign ops_o = '0;
`endif

    assign load_en  = (state == IDLE) && load_i;
    assign apply_en = (state == RUN);

    // Source lane per mode; with two lanes every non-hold mode reduces to a swap.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        localparam int L_IDX = (i + 1) % LANES;
        localparam int R_IDX = (i + LANES - 1) % LANES;
        localparam int S_IDX = (i % 2 == 1) ? i - 1 : ((i + 1 < LANES) ? i + 1 : i);

        assign lane_next[i] = (mode_q == ROT_L)     ? lanes_q[L_IDX] :
                              (mode_q == ROT_R)     ? lanes_q[R_IDX] :
                              (mode_q == PAIR_SWAP) ? lanes_q[S_IDX] :
                                                      lanes_q[i];

        assign data_o[i*WIDTH +: WIDTH] = lanes_q[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LANES; i++) lanes_q[i] <= '0;
        end else if (load_en) begin
            for (int i = 0; i < LANES; i++) lanes_q[i] <= data_i[i*WIDTH +: WIDTH];
        end else if (apply_en) begin
            lanes_q <= lane_next;
        end
    end

    // Control FSM; start is honoured only in IDLE and only when no load is requested.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            mode_q   <= HOLD;
            step_cnt <= '0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
`ifdef LANE_ROTATOR_OPS_CNT_EN
            ops_q    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done_o <= 1'b0;
                    if (start_i && !load_i) begin
                        mode_q   <= mode_t'(mode_i);
                        step_cnt <= steps_i;
`ifdef LANE_ROTATOR_OPS_CNT_EN
                        ops_q    <= '0;
`endif
                        if (steps_i != '0) begin
                            state  <= RUN;
                            busy_o <= 1'b1;
                        end else begin
                            state  <= DONE;
                            done_o <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    step_cnt <= step_cnt - STEP_W'(1);
`ifdef LANE_ROTATOR_OPS_CNT_EN
                    ops_q    <= ops_q + STEP_W'(1);
`endif
                    if (step_cnt == STEP_W'(1)) begin
                        state  <= DONE;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                    end
                end
                DONE: begin
                    done_o <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                    done_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lane_rotator.sv
// Directed self-checking bench for lane_rotator with WIDTH=8, LANES=4.
module tb_lane_rotator;

    logic        clk;
    logic        rst_n;
    logic        load_i;
    logic [31:0] data_i;
    logic        start_i;
    logic [1:0]  mode_i;
    logic [7:0]  steps_i;
    logic [31:0] data_o;
    logic        busy_o;
    logic        done_o;
    logic [7:0]  ops_o;

    int tests_run = 0;
    int tests_failed = 0;
    int busy_cnt;
    int done_cnt;
    int done_at;

`ifdef LANE_ROTATOR_OPS_CNT_EN
    localparam bit OPS_EN = 1'b1;
`else
    localparam bit OPS_EN = 1'b0;
`endif

    lane_rotator #(.WIDTH(8), .LANES(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (load_i),
        .data_i  (data_i),
        .start_i (start_i),
        .mode_i  (mode_i),
        .steps_i (steps_i),
        .data_o  (data_o),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .ops_o   (ops_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic load_data(input logic [31:0] value);
        @(negedge clk);
        load_i = 1'b1;
        data_i = value;
        @(negedge clk);
        load_i = 1'b0;
    endtask

    // Issue a start, then scramble mode/steps so any late sampling would show up.
    task automatic apply_stimulus(input logic [1:0] mode, input logic [7:0] steps, input logic with_load);
        @(negedge clk);
        start_i = 1'b1;
        mode_i  = mode;
        steps_i = steps;
        load_i  = with_load;
        data_i  = 32'h0A0B0C0D;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        load_i  = 1'b0;
        mode_i  = 2'b11;
        steps_i = 8'hFF;
    endtask

    // Sample n negedges after the start edge; index k follows edge k.
    task automatic run_window(input int n, input logic load_mid);
        busy_cnt = 0;
        done_cnt = 0;
        done_at  = -1;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (busy_o) busy_cnt++;
            if (done_o) begin
                done_cnt++;
                if (done_at < 0) done_at = c;
            end
            load_i = load_mid && busy_o;
            if (load_mid) data_i = 32'hAAAAAAAA;
        end
        load_i = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        load_i  = 1'b0;
        data_i  = '0;
        start_i = 1'b0;
        mode_i  = 2'b00;
        steps_i = '0;
        #12;
        check_output("reset_data", data_o, 32'h0);
        check_output("reset_busy", {31'b0, busy_o}, 32'h0);
        check_output("reset_done", {31'b0, done_o}, 32'h0);
        check_output("reset_ops", {24'b0, ops_o}, 32'h0);
        rst_n = 1'b1;

        load_data(32'h44332211);
        check_output("load", data_o, 32'h44332211);

        apply_stimulus(2'b01, 8'd1, 1'b0);
        run_window(4, 1'b0);
        check_output("rotl1_data", data_o, 32'h11443322);
        check_output("rotl1_done_at", done_at, 32'd1);
        check_output("rotl1_done_cnt", done_cnt, 32'd1);
        check_output("rotl1_busy", busy_cnt, 32'd1);
        check_output("rotl1_ops", {24'b0, ops_o}, OPS_EN ? 32'd1 : 32'd0);

        load_data(32'h44332211);
        apply_stimulus(2'b10, 8'd1, 1'b0);
        run_window(4, 1'b0);
        check_output("rotr1_data", data_o, 32'h33221144);

        load_data(32'h44332211);
        apply_stimulus(2'b11, 8'd1, 1'b0);
        run_window(4, 1'b0);
        check_output("swap1_data", data_o, 32'h33441122);

        load_data(32'h44332211);
        apply_stimulus(2'b01, 8'd4, 1'b0);
        run_window(7, 1'b0);
        check_output("rotl4_data", data_o, 32'h44332211);
        check_output("rotl4_busy", busy_cnt, 32'd4);
        check_output("rotl4_done_at", done_at, 32'd4);
        check_output("rotl4_ops", {24'b0, ops_o}, OPS_EN ? 32'd4 : 32'd0);

        load_data(32'h44332211);
        apply_stimulus(2'b01, 8'd0, 1'b0);
        run_window(3, 1'b0);
        check_output("steps0_data", data_o, 32'h44332211);
        check_output("steps0_busy", busy_cnt, 32'd0);
        check_output("steps0_done_at", done_at, 32'd0);
        check_output("steps0_ops", {24'b0, ops_o}, 32'd0);

        apply_stimulus(2'b00, 8'd3, 1'b0);
        run_window(6, 1'b0);
        check_output("hold3_data", data_o, 32'h44332211);
        check_output("hold3_busy", busy_cnt, 32'd3);
        check_output("hold3_done_at", done_at, 32'd3);

        apply_stimulus(2'b01, 8'd1, 1'b1);
        run_window(4, 1'b0);
        check_output("loadstart_data", data_o, 32'h0A0B0C0D);
        check_output("loadstart_busy", busy_cnt, 32'd0);
        check_output("loadstart_done", done_cnt, 32'd0);

        load_data(32'h44332211);
        apply_stimulus(2'b01, 8'd3, 1'b0);
        run_window(6, 1'b1);
        check_output("midload_data", data_o, 32'h33221144);
        check_output("midload_done_at", done_at, 32'd3);

        load_data(32'h44332211);
        apply_stimulus(2'b01, 8'd5, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_output("midrst_data", data_o, 32'h0);
        check_output("midrst_busy", {31'b0, busy_o}, 32'h0);
        check_output("midrst_done", {31'b0, done_o}, 32'h0);
        check_output("midrst_ops", {24'b0, ops_o}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        run_window(3, 1'b0);
        check_output("postrst_busy", busy_cnt, 32'd0);
        load_data(32'h12345678);
        check_output("postrst_load", data_o, 32'h12345678);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
